// File: rtl/typewriter_buffer_ctrl_pkg.sv
// Shared types and ASCII constants for the typewriter edit controller.
// States, decoded key operations and the printable-range helper.
package typewriter_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_EXEC
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CHAR,
    OP_BKSP,
    OP_NL,
    OP_ESC
  } op_t;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  function automatic logic is_printable(
    input logic [7:0] c
  );
    return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
  endfunction

endpackage

// File: rtl/typewriter_buffer_ctrl_if.sv
// Key-event and character-RAM write bundle of the edit controller.
// slave = controller side, master = key source / RAM / bench side.
interface typewriter_buffer_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              key_valid;
  logic              key_make;
  logic [7:0]        key_ascii;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] cursor;
  logic              busy;
  logic              drop;

  modport slave (
    input  key_valid, key_make, key_ascii,
    output we, wr_addr, wr_data,
    output cursor, busy, drop
  );

  modport master (
    output key_valid, key_make, key_ascii,
    input  we, wr_addr, wr_data,
    input  cursor, busy, drop
  );
endinterface

// File: rtl/typewriter_buffer_ctrl_key_classify.sv
// Combinational ASCII decode into an edit operation.
// Codes outside the supported set map to OP_NONE.
module key_classify
  import typewriter_pkg::*;
(
  input  logic [7:0] i_ascii,
  output op_t        o_op
);

  always_comb begin
    o_op = OP_NONE;
    unique case (1'b1)
      is_printable(i_ascii):    o_op = OP_CHAR;
      (i_ascii == ASCII_BS):    o_op = OP_BKSP;
      (i_ascii == ASCII_CR):    o_op = OP_NL;
      (i_ascii == ASCII_ESC):   o_op = OP_ESC;
      default:                  o_op = OP_NONE;
    endcase
  end

endmodule

// File: rtl/typewriter_buffer_ctrl.sv
// Edit controller owning the write port of the LCD character RAM.
// Clears the RAM after reset/ESC, then appends, erases and moves the cursor.
module typewriter_buffer_ctrl
  import typewriter_pkg::*;
#(
  parameter int         ADDR_W    = 6,
  parameter int         LINE_LEN  = 16,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  typewriter_buffer_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST  = '1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(LINE_LEN);
  localparam logic [ADDR_W-1:0] LMASK = ~ADDR_W'(LINE_LEN - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_cursor;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_we;
  logic              r_drop;

  op_t  w_op;
  logic w_key;

  assign w_key = bus.key_valid & bus.key_make;

  key_classify u_classify (
    .i_ascii (bus.key_ascii),
    .o_op    (w_op)
  );

  // The accepting cycle issues the write so it is visible during EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_CLEAR;
      r_cnt    <= '0;
      r_cursor <= '0;
      r_addr   <= '0;
      r_data   <= FILL_CHAR;
      r_we     <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_drop <= 1'b0;
      unique case (r_state)
        ST_CLEAR: begin
          r_we   <= 1'b1;
          r_addr <= r_cnt;
          r_data <= FILL_CHAR;
          r_cnt  <= r_cnt + 1'b1;
          r_drop <= w_key;
          if (r_cnt == LAST) begin
            r_state  <= ST_IDLE;
            r_cursor <= '0;
          end
        end
        ST_IDLE: begin
          if (w_key) begin
            unique case (w_op)
              OP_CHAR: begin
                r_state  <= ST_EXEC;
                r_we     <= 1'b1;
                r_addr   <= r_cursor;
                r_data   <= bus.key_ascii;
                r_cursor <= r_cursor + 1'b1;
              end
              OP_BKSP: begin
                r_state <= ST_EXEC;
                if (r_cursor != '0) begin
                  r_we     <= 1'b1;
                  r_addr   <= r_cursor - 1'b1;
                  r_data   <= FILL_CHAR;
                  r_cursor <= r_cursor - 1'b1;
                end
              end
              OP_NL: begin
                r_state  <= ST_EXEC;
                r_cursor <= (r_cursor & LMASK) + STEP;
              end
              OP_ESC: begin
                r_state <= ST_CLEAR;
                r_cnt   <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_EXEC: begin
          r_state <= ST_IDLE;
          r_drop  <= w_key;
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.we      = r_we;
  assign bus.wr_addr = r_addr;
  assign bus.wr_data = r_data;
  assign bus.cursor  = r_cursor;
  assign bus.drop    = r_drop;
  assign bus.busy    = (r_state != ST_IDLE);

endmodule
